mmio_ahb_apb_bridge: RTL

//  AHB-Lite slave to APB3 master bridge on the Mi-V MMIO master port (downstream of PROCESSOR).

---
 rtl/mmio_ahb_apb_bridge.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mmio_ahb_apb_bridge.sv
// mmio_ahb_apb_bridge: AHB-Lite slave to APB3 master bridge on the Mi-V MMIO port.
// Each word transfer becomes one APB SETUP/ACCESS cycle; sub-word, PSLVERR and PREADY timeout give an AHB ERROR.
module mmio_ahb_apb_bridge #(
   parameter int APB_AW      = 16,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              HSEL,
   input  logic [30:0]       HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [31:0]       HRDATA,
   output logic [APB_AW-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WDAT,
      S_SETUP,
      S_ACCESS,
      S_DONE,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [APB_AW-1:2]   addr_q;
   logic                write_q;
   logic [15:0]         count;
   logic                accept;
   logic                can_accept;
   logic                word_ok;
   logic                timeout_hit;
   logic                unused_ok;

   assign can_accept  = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
   assign accept      = HSEL & HTRANS[1] & HREADY;
   assign word_ok     = (HSIZE == 3'b010);
   assign timeout_hit = (count == 16'(TIMEOUT_CYC - 1));

   // Address bits above the APB window, byte lanes and HTRANS[0] carry no meaning here.
   assign unused_ok = &{1'b0, HADDR[30:APB_AW], HADDR[1:0], HTRANS[0]};

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // the pre-edge value of every other flop, independent of block order.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output gets a default before the case so no path can infer a latch.
      state_nxt = state;
      HREADYOUT = 1'b0;
      HRESP     = 1'b0;
      PSEL      = 1'b0;
      PENABLE   = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERR2: begin
            HREADYOUT = 1'b1;
            HRESP     = (state == S_ERR2);
            if (accept) begin
               state_nxt = word_ok ? S_WDAT : S_ERR1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_WDAT: begin
            state_nxt = S_SETUP;
         end
         S_SETUP: begin
            PSEL      = 1'b1;
            state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            // A late PREADY on the final allowed cycle still wins over the abort.
            if (PREADY) begin
               state_nxt = PSLVERR ? S_ERR1 : S_DONE;
            end else if (timeout_hit) begin
               state_nxt = S_ERR1;
            end
         end
         S_ERR1: begin
            HRESP     = 1'b1;
            state_nxt = S_ERR2;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         addr_q  <= '0;
         write_q <= 1'b0;
      end else if (can_accept && accept) begin
         addr_q  <= HADDR[APB_AW-1:2];
         write_q <= HWRITE;
      end
   end

   // APB address/direction/data are loaded in the HWDATA phase and then held until the next SETUP.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         PADDR  <= '0;
         PWRITE <= 1'b0;
         PWDATA <= '0;
      end else if (state == S_WDAT) begin
         PADDR  <= {addr_q, 2'b00};
         PWRITE <= write_q;
         if (write_q) begin
            PWDATA <= HWDATA;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         count <= '0;
      end else if (state == S_SETUP) begin
         count <= '0;
      end else if ((state == S_ACCESS) && !PREADY) begin
         count <= count + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         HRDATA <= '0;
      end else if ((state == S_ACCESS) && PREADY && !PSLVERR && !write_q) begin
         HRDATA <= PRDATA;
      end
   end

endmodule
